// File: rtl/routed_store_pkg.sv
// rtl/routed_store_pkg.sv - shared constants for the routed store demultiplexer
package routed_store_pkg;

    // Steering mode encoding
    localparam logic MODE_ADDR = 1'b0;
    localparam logic MODE_SEQ  = 1'b1;

    // Default geometry
    localparam int DEFAULT_WIDTH    = 8;
    localparam int DEFAULT_CHANNELS = 4;

    // Refused-offer counter geometry
    localparam int                    DROP_CNT_W   = 8;
    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

endpackage

// File: rtl/routed_store_slot.sv
// rtl/routed_store_slot.sv - one channel holding register with full flag
module routed_store_slot
    import routed_store_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             ack,
    output logic [WIDTH-1:0] data,
    output logic             full
);

    // Stored word: loaded on a write, otherwise held (an ack does not clear it)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
        end else if (wr_en) begin
            data <= wr_data;
        end
    end

    // Full flag: a write is only offered to an empty slot, so write and ack never
    // collide on a full slot; an ack on an empty slot is a no-op
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
        end else if (wr_en) begin
            full <= 1'b1;
        end else if (ack) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/routed_store_demux.sv
// rtl/routed_store_demux.sv - registered demux into flow-controlled channels (option: ROUTED_STORE_DROP_CNT_EN)
module routed_store_demux
    import routed_store_pkg::*;
#(
    parameter int  WIDTH    = DEFAULT_WIDTH,
    parameter int  CHANNELS = DEFAULT_CHANNELS,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [WIDTH-1:0]          in_data,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      mode,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [CHANNELS-1:0]       out_full,
    input  logic [CHANNELS-1:0]       rd_ack,
    output logic [DROP_CNT_W-1:0]     drop_cnt
);

    localparam logic [SEL_W-1:0] PTR_LAST = SEL_W'(CHANNELS - 1);

    logic [SEL_W-1:0]    ptr;
    logic [SEL_W-1:0]    target;
    logic                target_valid;
    logic                target_full;
    logic                xfer;
    logic [CHANNELS-1:0] wr_en;

    // Pick the channel this cycle's offer is aimed at
    always_comb begin
        target = (mode == MODE_SEQ) ? ptr : in_sel;
    end

    // Look up the target's full flag; codes past the last channel match nothing
    always_comb begin
        target_valid = 1'b0;
        target_full  = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (target == SEL_W'(k)) begin
                target_valid = 1'b1;
                target_full  = out_full[k];
            end
        end
    end

    // Ready uses the pre-ack full flag, so an ack and an offer to the same
    // channel in one cycle refuses the offer
    assign in_ready = target_valid && !target_full;
    assign xfer     = in_valid && in_ready;

    // One-hot write strobe to the target slot
    always_comb begin
        wr_en = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            wr_en[k] = xfer && (target == SEL_W'(k));
        end
    end

    // Round-robin pointer: moves only on a sequential-mode transfer, wraps at the last channel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (xfer && (mode == MODE_SEQ)) begin
            ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_slot
        routed_store_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_en   (wr_en[g]),
            .wr_data (in_data),
            .ack     (rd_ack[g]),
            .data    (out_data[g*WIDTH +: WIDTH]),
            .full    (out_full[g])
        );
    end

`ifdef ROUTED_STORE_DROP_CNT_EN
    // Count cycles where an offer was refused, saturating; cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (in_valid && !in_ready && (drop_cnt != DROP_CNT_MAX)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end
`else
    assign drop_cnt = '0;
`endif

    // The pointer must never address a channel that does not exist
    ptr_in_range: assert property (@(posedge clk) disable iff (!rst_n) int'(ptr) < CHANNELS);

endmodule

// File: doc/routed_store_demux.md
# routed_store_demux

Parametrised registered demultiplexer. It steers a WIDTH-bit input word into one of CHANNELS holding registers, selected either by an explicit address or by an internal round-robin pointer. Each channel holds its word and a full flag until the consumer acknowledges it. Back-pressure is applied through a valid/ready handshake. It sits between the input capture logic and the per-channel storage/display consumers, replacing the combinational 4-way steering with stored, flow-controlled channels.

## Interface
- WIDTH, 8, data word width (≥1)
- CHANNELS, 4, number of output channels (≥2)
- SEL_W, derived localparam = $clog2(CHANNELS), not overridable
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous assert, active-low
- in_data  in  WIDTH  word to store
- in_sel  in  SEL_W  target channel in addressed mode; ignored in sequential mode
- in_valid  in  1  in_data/in_sel valid this cycle
- in_ready  out  1  target channel can accept; transfer occurs when in_valid && in_ready
- mode  in  1  0 = addressed, 1 = sequential (round-robin)
- out_data  out  CHANNELS*WIDTH  channel k at bits [k*WIDTH +: WIDTH]
- out_full  out  CHANNELS  channel k holds an unacknowledged word
- rd_ack  in  CHANNELS  consumer acknowledges channel k; clears out_full[k]
- drop_cnt  out  8  saturating count of refused offers (see Configuration)

## Operation
- Target channel: in_sel when mode=0, otherwise ptr (internal SEL_W-bit counter).
- in_ready = !out_full[target]. It is combinational from registered state and mode/in_sel, and never depends on in_valid.
- On a transfer, out_data[target] ← in_data and out_full[target] ← 1. All other channels are unchanged; unselected channels keep their contents and are not zeroed.
- In sequential mode, ptr advances by 1 on each transfer and wraps from CHANNELS-1 to 0. It does not advance without a transfer. For non-power-of-2 CHANNELS, ptr never reaches CHANNELS.
- In addressed mode, ptr holds its value. Switching mode neither resets nor moves ptr.
- In addressed mode, in_sel ≥ CHANNELS (non-power-of-2 only) gives in_ready=0 and nothing is written.
- rd_ack[k] with out_full[k]=1 clears out_full[k] next edge; out_data[k] keeps its value. rd_ack[k] with out_full[k]=0 is ignored.
- Same cycle, same channel, rd_ack plus an offer: the offer is refused, because in_ready uses the pre-ack full flag. The flag clears and the word can be accepted the following cycle.
- Same cycle, different channels, rd_ack plus a transfer: both take effect.
- rd_ack may be asserted on any number of channels at once.

## Timing
- Reset (rst_n=0, async): out_data=0, out_full=0, ptr=0, drop_cnt=0. in_ready therefore reads 1 during and after reset.
- Write latency: 1 cycle from the accepting edge to out_data/out_full.
- Ack latency: 1 cycle to clear out_full.
- Best-case throughput is one word per cycle. This happens when the targets are not full, including sequential mode sweeping all channels.
- Reset mid-operation clears all state immediately. A transfer on the same edge as reset assertion is lost.
- Deassertion of rst_n is synchronised externally; the block does no reset synchronisation.

## Configuration
- Macro ROUTED_STORE_DROP_CNT_EN.
- Defined: drop_cnt increments on every cycle with in_valid && !in_ready and saturates at 255. It is cleared only by reset.
- Undefined: no counter logic is compiled, and drop_cnt is driven constant 0.

## Structure
- Package routed_store_pkg:
  - MODE_ADDR=1'b0 and MODE_SEQ=1'b1.
  - Default WIDTH/CHANNELS.
  - DROP_CNT_W=8 and DROP_CNT_MAX.
- One sub-module, routed_store_slot: one channel's WIDTH-bit register and full flag, with inputs wr_en, wr_data, ack. It is instantiated CHANNELS times with a generate loop. The top level holds ptr, target decode, in_ready and drop_cnt.

## Test plan
- Reset then addressed writes 0xA1→ch2 and 0xB2→ch0 → out_data ch2=0xA1, ch0=0xB2, out_full=4'b0101, ch1/ch3 remain 0.
- Addressed write to full ch1 with in_valid held 3 cycles, rd_ack[1] in cycle 2 → in_ready=0 for two cycles, new word accepted in cycle 3; with the macro enabled, drop_cnt=2.
- Sequential mode with 5 offers 0x10..0x14 and ack of ch0 after its first fill → ch0..3 = 0x10..0x13, then 0x14 lands in ch0 after the wrap.
- Mode toggle: 2 sequential writes (ptr=2), 1 addressed write to ch3, back to sequential → next word lands in ch2.
- rst_n pulsed low mid-stream with channels full → all outputs 0 asynchronously; first post-reset sequential write goes to ch0.
- CHANNELS=3, WIDTH=12, addressed in_sel=3 → in_ready=0, no channel changes, drop_cnt increments (macro on) or stays 0 (macro off).
